alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares one `alu` instance, instantiated inside this block, between two requesters (e.g. the main execute path and a secondary unit such as a branch or address helper).
- Each requester uses a valid/ready handshake. Round-robin arbitration picks one request per cycle.
- Granted operands and opcode are registered and presented to the ALU; the tagged result is returned on a single response channel with valid/ready backpressure.
- Throughput is one operation per cycle when the response side is not stalled.

Parameters:
DATA_WIDTH, 32, operand/result width, passed to the internal alu
OPCODE_LENGTH, 4, ALU operation code width, passed to the internal alu

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  DATA_WIDTH  requester 0 SrcA
req0_b  input  DATA_WIDTH  requester 0 SrcB
req0_op  input  OPCODE_LENGTH  requester 0 ALU operation
req1_valid  input  1  requester 1 has an operation
req1_ready  output  1  requester 1 operation accepted this cycle
req1_a  input  DATA_WIDTH  requester 1 SrcA
req1_b  input  DATA_WIDTH  requester 1 SrcB
req1_op  input  OPCODE_LENGTH  requester 1 ALU operation
rsp_valid  output  1  response holds a valid result
rsp_ready  input  1  consumer takes response this cycle
rsp_id  output  1  requester index owning the response
rsp_result  output  DATA_WIDTH  ALU result for the held operation

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- States: IDLE (rsp_valid=0) and HOLD (rsp_valid=1). Internal registers: op_a, op_b, op_code, id, last_grant.
- Reset values:
  - state=IDLE, rsp_valid=0, rsp_id=0.
  - op_a=op_b=0, op_code=0, so rsp_result=0.
  - last_grant=1, so requester 0 wins the first conflict.
  - Reset overrides everything, including a HOLD in progress: the held response is dropped and no ready is asserted in the reset cycle.
- can_accept = (state==IDLE) | rsp_ready. This is a combinational path from rsp_ready to reqN_ready and is accepted by design.
- Grant, combinational, only when can_accept:
  - Only one valid: grant that requester.
  - Both valid: grant the requester != last_grant.
  - Neither valid: no grant.
- reqN_ready = can_accept & grant==N. At most one ready is high per cycle. Ready never asserts for a requester whose valid is low.
- On a grant edge:
  - Capture op_a/op_b/op_code from the granted requester; id <= N; last_grant <= N; state <= HOLD.
  - last_grant changes only on a grant.
- State exits without a grant:
  - HOLD with rsp_ready=1 and no grant -> IDLE.
  - HOLD with rsp_ready=0 -> stay in HOLD. All registers are frozen and rsp_result/rsp_id are stable until the transfer.
- Latency: accept at edge k, rsp_valid=1 from the cycle after edge k. rsp_result is combinational from the alu fed by the registered operands, with no extra register.
- Back-to-back: response transfer and new accept in the same cycle are allowed. The next response is presented in the following cycle with no bubble.
- Output gating: rsp_result is forced to 0 when rsp_valid=0. rsp_id holds its last value when idle.
- ALU semantics are unchanged:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SUB.
  - 0101 NE, 0110 LT, 0111 GE, 1000 EQ; each gives 1/0, compare unsigned.
  - Any other op gives 0.
  - ADD/SUB wrap modulo 2^DATA_WIDTH.
- A requester must hold valid and its payload stable until ready. The block does not check this.

Test Plan:
- Reset then idle: assert reset 2 cycles with both valids low -> rsp_valid=0, rsp_result=0, both ready=0.
- Single request: req0 ADD a=5 b=7 with rsp_ready=1 -> req0_ready=1 in the accept cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=12.
- Conflict fairness: both valid every cycle (req0 SUB 10-3, req1 XOR 0xF0^0x0F) with rsp_ready=1 -> grants alternate 0,1,0,1. Responses: 7 (id0), 0xFF (id1), repeating, with rsp_valid high every cycle.
- Backpressure: req1 ADD 0xFFFFFFFF+1 accepted, then rsp_ready=0 for 3 cycles with req0 valid -> rsp_result=0, rsp_id=1 stable; both ready=0 for those 3 cycles; req0 accepted in the cycle rsp_ready returns to 1.
- Compare and unknown ops: req0 LT a=0xFFFFFFFF b=1 -> 0; req0 GE same -> 1; req1 op=4'b1111 -> 0.
- Reset mid-operation: reset during HOLD with rsp_ready=0 -> rsp_valid=0 the next cycle. Then a conflict after reset grants req0 first.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared ALU: round-robin grant, registered
// operands, and a single tagged response slot with valid/ready backpressure.

module alu #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic [DATA_WIDTH-1:0]    a_i,
  input  logic [DATA_WIDTH-1:0]    b_i,
  input  logic [OPCODE_LENGTH-1:0] op_i,
  output logic [DATA_WIDTH-1:0]    result_o
);

  localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(0);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(1);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(2);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(3);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4);
  localparam logic [OPCODE_LENGTH-1:0] OP_NE  = OPCODE_LENGTH'(5);
  localparam logic [OPCODE_LENGTH-1:0] OP_LT  = OPCODE_LENGTH'(6);
  localparam logic [OPCODE_LENGTH-1:0] OP_GE  = OPCODE_LENGTH'(7);
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(8);

  function automatic logic [DATA_WIDTH-1:0] flag(input logic b);
    return {{(DATA_WIDTH-1){1'b0}}, b};
  endfunction

  // Comparisons are unsigned; ADD/SUB wrap naturally at DATA_WIDTH bits.
  always_comb begin
    result_o = '0;
    case (op_i)
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_ADD:  result_o = a_i + b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_NE:   result_o = flag(a_i != b_i);
      OP_LT:   result_o = flag(a_i < b_i);
      OP_GE:   result_o = flag(a_i >= b_i);
      OP_EQ:   result_o = flag(a_i == b_i);
      default: result_o = '0;
    endcase
  end

endmodule

module alu_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [DATA_WIDTH-1:0]    req0_a,
  input  logic [DATA_WIDTH-1:0]    req0_b,
  input  logic [OPCODE_LENGTH-1:0] req0_op,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [DATA_WIDTH-1:0]    req1_a,
  input  logic [DATA_WIDTH-1:0]    req1_b,
  input  logic [OPCODE_LENGTH-1:0] req1_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [DATA_WIDTH-1:0]    rsp_result
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    op_a_q, op_b_q;
  logic [OPCODE_LENGTH-1:0] op_code_q;
  logic                     id_q;
  logic                     last_grant_q;

  logic                     can_accept;
  logic                     grant_vld;
  logic                     grant_id;
  logic [DATA_WIDTH-1:0]    alu_result;

  // The response slot frees up in the same cycle it is consumed, so
  // rsp_ready feeds straight through to the request-side readies.
  assign can_accept = ~reset & ((state_q == IDLE) | rsp_ready);

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (can_accept) begin
      if (req0_valid && req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = ~last_grant_q;
      end else if (req0_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end else if (req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (grant_vld)                          state_d = HOLD;
    else if (state_q == HOLD && rsp_ready)  state_d = IDLE;
  end

  // Output logic
  always_comb begin
    req0_ready = grant_vld & ~grant_id;
    req1_ready = grant_vld &  grant_id;
    rsp_valid  = (state_q == HOLD);
  end

  // Operand capture; everything stays frozen while a response waits.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_code_q    <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (grant_vld) begin
      op_a_q       <= grant_id ? req1_a  : req0_a;
      op_b_q       <= grant_id ? req1_b  : req0_b;
      op_code_q    <= grant_id ? req1_op : req0_op;
      id_q         <= grant_id;
      last_grant_q <= grant_id;
    end
  end

  alu #(
    .DATA_WIDTH   (DATA_WIDTH),
    .OPCODE_LENGTH(OPCODE_LENGTH)
  ) u_alu (
    .a_i     (op_a_q),
    .b_i     (op_b_q),
    .op_i    (op_code_q),
    .result_o(alu_result)
  );

  assign rsp_id     = id_q;
  assign rsp_result = rsp_valid ? alu_result : '0;

endmodule
